nrisc_mem_responder: RTL and testbench
======================================

// Module: nrisc_mem_responder
// PURPOSE
//  Responder end of the nRisc memory interface: unified 8-bit instruction/data RAM
//  that answers the core's PC fetch and its MemRead/MemWrite data accesses.
//  Adds a byte-stream program loader (valid/ready) that fills RAM from address 0
//  and holds the core stalled until the image is complete.
//  Sits beside the nRisc core at SoC top level; the core needs no wait-state logic.
// PARAMETERS
//  ADDR_W    8    address width; RAM depth = 2**ADDR_W words
//  DATA_W    8    word width (instruction = data word)
//  LOAD_LEN  256  bytes per program image, 1..2**ADDR_W
// PORTS
//  Clock       in   1       rising-edge clock
//  reset       in   1       asynchronous, active-high reset
//  InstrAddr   in   ADDR_W  fetch address (core PC)
//  Instrucao   out  DATA_W  fetched instruction
//  DataAddr    in   ADDR_W  data address (core ALU result)
//  WriteData   in   DATA_W  store data from core
//  MemRead     in   1       load strobe
//  MemWrite    in   1       store strobe
//  LeDado      out  DATA_W  load data to core
//  load_start  in   1       request (re)load of program image
//  load_valid  in   1       loader byte valid
//  load_data   in   DATA_W  loader byte
//  load_ready  out  1       responder accepts loader byte
//  cpu_hold    out  1       core must be held in reset/stalled
//  load_count  out  ADDR_W+1  bytes accepted in current load
//  conflict    out  1       sticky: MemRead&MemWrite seen together in RUN
// BEHAVIOUR
//  - States: ST_LOAD, ST_RUN. reset -> ST_LOAD, load_count=0, conflict=0;
//    RAM contents are NOT reset.
//  - Outputs: load_ready=cpu_hold=(state==ST_LOAD); both 1 during/after reset.
//  - ST_LOAD: byte accepted when load_valid&load_ready at posedge; written to
//    mem[load_count], load_count++. Acceptance of byte LOAD_LEN-1 -> ST_RUN next
//    cycle, load_count holds LOAD_LEN. load_valid low: no change (stalls freely).
//  - ST_LOAD: core strobes ignored (no RAM write); Instrucao=0, LeDado=0.
//  - ST_RUN: Instrucao=mem[InstrAddr], combinational, zero latency.
//    LeDado=MemRead ? mem[DataAddr] : 0, combinational.
//    MemWrite: mem[DataAddr]<=WriteData at posedge; visible on reads next cycle.
//  - Same-cycle MemRead&MemWrite: write performed; LeDado returns pre-write
//    value; conflict<=1 (sticky until reset).
//  - Store to InstrAddr same cycle: Instrucao shows old word this cycle.
//  - load_start in ST_RUN -> ST_LOAD next cycle, load_count<=0, conflict kept;
//    load_start in ST_LOAD restarts at address 0 (byte in that cycle discarded).
//  - Addresses wrap naturally at 2**ADDR_W; no out-of-range state exists.
//  - reset mid-load: partial image stays in RAM, counter restarts at 0.
// STRUCTURE
//  - Shared package nrisc_pkg: state enum (ST_LOAD, ST_RUN), NRISC_DATA_W,
//    NRISC_ADDR_W constants.
//  - One sub-module: nrisc_ram_2r1w (two async read ports, one sync write port,
//    no reset). Write port muxed between loader and core by state.
//  - FSM, load counter, conflict flag in this module.
// TESTING
//  - Reset then 4-byte image LOAD_LEN=4 {0x11,0x22,0x33,0x44} -> cpu_hold drops
//    cycle after 4th accept; InstrAddr=2 -> Instrucao=0x33; load_count=4.
//  - load_valid toggled 1/0 every cycle -> exactly one write per valid beat,
//    bytes land at addresses 0..3 in order.
//  - RUN: MemWrite DataAddr=0x80 WriteData=0xA5, next cycle MemRead 0x80 ->
//    LeDado=0xA5; MemRead=0 -> LeDado=0.
//  - RUN: MemRead&MemWrite addr 0x10 (old 0x5A, new 0xC3) -> LeDado=0x5A,
//    conflict=1, next read 0xC3; conflict stays 1 until reset.
//  - ST_LOAD: MemWrite addr 0x00 data 0xFF -> RAM unchanged, LeDado=0, Instrucao=0.
//  - reset asserted after 2 of 4 bytes -> cpu_hold=1, load_count=0 async; reload
//    from address 0; load_start in RUN -> cpu_hold=1 next cycle.

Source files
------------

// File: rtl/nrisc_pkg.sv
// Shared definitions for the nRisc memory responder.
//   NRISC_ADDR_W  : default address width (RAM depth = 2**NRISC_ADDR_W words)
//   NRISC_DATA_W  : default word width (instruction word = data word)
//   nrisc_state_e : responder mode, ST_LOAD (image loading, core held) or ST_RUN
package nrisc_pkg;

  localparam int unsigned NRISC_ADDR_W = 8;
  localparam int unsigned NRISC_DATA_W = 8;

  typedef enum logic [0:0] {
    ST_LOAD,
    ST_RUN
  } nrisc_state_e;

endpackage

// File: rtl/nrisc_ram_2r1w.sv
// Unified instruction/data RAM: two asynchronous read ports, one synchronous write
// port. Contents are deliberately not reset so a loaded image survives a reset.
// Ports:
//   clk             rising-edge write clock
//   we/waddr/wdata  write port, sampled at posedge clk
//   raddr_a/rdata_a read port A (instruction fetch), combinational
//   raddr_b/rdata_b read port B (data load), combinational
module nrisc_ram_2r1w #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Reads see the pre-write contents during a write cycle.
  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/nrisc_mem_responder.sv
// Responder end of the nRisc memory interface. Holds the unified RAM, answers the
// core's fetch and load/store accesses, and fills RAM from address 0 with a
// valid/ready byte stream while keeping the core stalled.
// Ports:
//   Clock, reset            clock; asynchronous active-high reset
//   InstrAddr -> Instrucao  fetch address / fetched word (0 while loading)
//   DataAddr, WriteData     core data address and store data
//   MemRead, MemWrite       core load / store strobes (ignored while loading)
//   LeDado                  load data (0 unless running and MemRead)
//   load_start              request a (re)load of the program image
//   load_valid/load_data    loader byte stream; load_ready accepts it
//   cpu_hold                core must be held while loading
//   load_count              bytes accepted in the current load
//   conflict                sticky flag: MemRead and MemWrite together while running
module nrisc_mem_responder
  import nrisc_pkg::*;
#(
  parameter int unsigned ADDR_W   = NRISC_ADDR_W,
  parameter int unsigned DATA_W   = NRISC_DATA_W,
  parameter int unsigned LOAD_LEN = 256
) (
  input  logic              Clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] InstrAddr,
  output logic [DATA_W-1:0] Instrucao,
  input  logic [ADDR_W-1:0] DataAddr,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              MemRead,
  input  logic              MemWrite,
  output logic [DATA_W-1:0] LeDado,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              cpu_hold,
  output logic [ADDR_W:0]   load_count,
  output logic              conflict
);

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(LOAD_LEN - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

  nrisc_state_e      state;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata_i;
  logic [DATA_W-1:0] ram_rdata_d;
  logic              loading;

  assign loading    = (state == ST_LOAD);
  assign load_ready = loading;
  assign cpu_hold   = loading;

  // Mode, loader counter and conflict flag.
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state      <= ST_LOAD;
      load_count <= '0;
      conflict   <= 1'b0;
    end else begin
      unique case (state)
        ST_LOAD: begin
          // A restart wins over a byte offered in the same cycle.
          if (load_start) begin
            load_count <= '0;
          end else if (load_valid) begin
            load_count <= load_count + CNT_ONE;
            if (load_count == LAST_IDX) begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (MemRead && MemWrite) begin
            conflict <= 1'b1;
          end
          if (load_start) begin
            state      <= ST_LOAD;
            load_count <= '0;
          end
        end
      endcase
    end
  end

  // The single write port belongs to the loader while loading, to the core otherwise.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = DataAddr;
    ram_wdata = WriteData;
    if (loading) begin
      ram_we    = load_valid && !load_start;
      ram_waddr = load_count[ADDR_W-1:0];
      ram_wdata = load_data;
    end else begin
      ram_we    = MemWrite;
    end
  end

  nrisc_ram_2r1w #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (Clock),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .raddr_a (InstrAddr),
    .rdata_a (ram_rdata_i),
    .raddr_b (DataAddr),
    .rdata_b (ram_rdata_d)
  );

  assign Instrucao = loading ? '0 : ram_rdata_i;
  assign LeDado    = (!loading && MemRead) ? ram_rdata_d : '0;

endmodule

// File: tb/tb_nrisc_mem_responder.sv
module tb_nrisc_mem_responder;

  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 8;
  localparam int unsigned LEN = 4;

  logic          Clock;
  logic          reset;
  logic [AW-1:0] InstrAddr;
  logic [DW-1:0] Instrucao;
  logic [AW-1:0] DataAddr;
  logic [DW-1:0] WriteData;
  logic          MemRead;
  logic          MemWrite;
  logic [DW-1:0] LeDado;
  logic          load_start;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_ready;
  logic          cpu_hold;
  logic [AW:0]   load_count;
  logic          conflict;

  nrisc_mem_responder #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .LOAD_LEN (LEN)
  ) dut (
    .Clock      (Clock),
    .reset      (reset),
    .InstrAddr  (InstrAddr),
    .Instrucao  (Instrucao),
    .DataAddr   (DataAddr),
    .WriteData  (WriteData),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .LeDado     (LeDado),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .cpu_hold   (cpu_hold),
    .load_count (load_count),
    .conflict   (conflict)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Directed vectors: inputs for one cycle and the outputs expected before its edge.
  typedef struct {
    logic          st;
    logic          lv;
    logic [DW-1:0] ld;
    logic          mr;
    logic          mw;
    logic [AW-1:0] ia;
    logic [AW-1:0] da;
    logic [DW-1:0] wd;
    logic          e_hold;
    logic [DW-1:0] e_instr;
    logic [DW-1:0] e_led;
    logic [AW:0]   e_cnt;
    logic          e_conf;
  } vec_t;

  vec_t vecs[$];

  // Reference model: memory image, mode, byte count and sticky flag.
  logic [DW-1:0] mem_m [2**AW];
  bit            run_m;
  int            cnt_m;
  bit            conf_m;

  task automatic model_cycle();
    logic [DW-1:0] e_instr;
    logic [DW-1:0] e_led;
    #1;
    e_instr = run_m ? mem_m[InstrAddr] : '0;
    e_led   = (run_m && MemRead) ? mem_m[DataAddr] : '0;
    check("m_hold", 32'(cpu_hold), 32'(!run_m));
    check("m_ready", 32'(load_ready), 32'(!run_m));
    check("m_instr", 32'(Instrucao), 32'(e_instr));
    check("m_ledado", 32'(LeDado), 32'(e_led));
    check("m_count", 32'(load_count), 32'(cnt_m));
    check("m_conflict", 32'(conflict), 32'(conf_m));
    if (!run_m) begin
      if (load_start) begin
        cnt_m = 0;
      end else if (load_valid) begin
        mem_m[cnt_m] = load_data;
        cnt_m++;
        if (cnt_m == LEN) run_m = 1;
      end
    end else begin
      if (MemWrite) mem_m[DataAddr] = WriteData;
      if (MemRead && MemWrite) conf_m = 1;
      if (load_start) begin
        run_m = 0;
        cnt_m = 0;
      end
    end
    @(posedge Clock);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    InstrAddr  = '0;
    DataAddr   = '0;
    WriteData  = '0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;

    //                 st lv ld     mr mw ia     da     wd   | hold instr  led    cnt conf
    vecs.push_back(vec_t'{0, 1, 8'h11, 1, 1, 8'h00, 8'h00, 8'hFF, 1, 8'h00, 8'h00, 9'd0, 0});
    vecs.push_back(vec_t'{0, 0, 8'hEE, 0, 0, 8'h00, 8'h00, 8'h00, 1, 8'h00, 8'h00, 9'd1, 0});
    vecs.push_back(vec_t'{0, 1, 8'h22, 0, 0, 8'h00, 8'h00, 8'h00, 1, 8'h00, 8'h00, 9'd1, 0});
    vecs.push_back(vec_t'{0, 0, 8'hEE, 0, 0, 8'h00, 8'h00, 8'h00, 1, 8'h00, 8'h00, 9'd2, 0});
    vecs.push_back(vec_t'{0, 1, 8'h33, 0, 0, 8'h00, 8'h00, 8'h00, 1, 8'h00, 8'h00, 9'd2, 0});
    vecs.push_back(vec_t'{0, 0, 8'h99, 0, 0, 8'h00, 8'h00, 8'h00, 1, 8'h00, 8'h00, 9'd3, 0});
    vecs.push_back(vec_t'{0, 1, 8'h44, 0, 0, 8'h00, 8'h00, 8'h00, 1, 8'h00, 8'h00, 9'd3, 0});
    vecs.push_back(vec_t'{0, 0, 8'h00, 1, 0, 8'h02, 8'h00, 8'h00, 0, 8'h33, 8'h11, 9'd4, 0});
    vecs.push_back(vec_t'{0, 0, 8'h00, 1, 0, 8'h01, 8'h03, 8'h00, 0, 8'h22, 8'h44, 9'd4, 0});
    vecs.push_back(vec_t'{0, 0, 8'h00, 0, 1, 8'h00, 8'h80, 8'hA5, 0, 8'h11, 8'h00, 9'd4, 0});
    vecs.push_back(vec_t'{0, 0, 8'h00, 1, 0, 8'h00, 8'h80, 8'h00, 0, 8'h11, 8'hA5, 9'd4, 0});
    vecs.push_back(vec_t'{0, 0, 8'h00, 0, 1, 8'h00, 8'h10, 8'h5A, 0, 8'h11, 8'h00, 9'd4, 0});
    vecs.push_back(vec_t'{0, 0, 8'h00, 1, 1, 8'h00, 8'h10, 8'hC3, 0, 8'h11, 8'h5A, 9'd4, 0});
    vecs.push_back(vec_t'{0, 0, 8'h00, 1, 0, 8'h00, 8'h10, 8'h00, 0, 8'h11, 8'hC3, 9'd4, 1});
    vecs.push_back(vec_t'{0, 0, 8'h00, 0, 1, 8'h02, 8'h02, 8'h77, 0, 8'h33, 8'h00, 9'd4, 1});
    vecs.push_back(vec_t'{0, 0, 8'h00, 0, 0, 8'h02, 8'h00, 8'h00, 0, 8'h77, 8'h00, 9'd4, 1});
    vecs.push_back(vec_t'{1, 0, 8'h00, 0, 0, 8'h02, 8'h00, 8'h00, 0, 8'h77, 8'h00, 9'd4, 1});
    vecs.push_back(vec_t'{0, 0, 8'h00, 1, 0, 8'h02, 8'h00, 8'h00, 1, 8'h00, 8'h00, 9'd0, 1});
    vecs.push_back(vec_t'{1, 1, 8'hAB, 0, 0, 8'h00, 8'h00, 8'h00, 1, 8'h00, 8'h00, 9'd0, 1});
    vecs.push_back(vec_t'{0, 1, 8'hD0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 8'h00, 8'h00, 9'd0, 1});
    vecs.push_back(vec_t'{0, 1, 8'hD1, 0, 0, 8'h00, 8'h00, 8'h00, 1, 8'h00, 8'h00, 9'd1, 1});
    vecs.push_back(vec_t'{1, 1, 8'hEE, 0, 0, 8'h00, 8'h00, 8'h00, 1, 8'h00, 8'h00, 9'd2, 1});
    vecs.push_back(vec_t'{0, 1, 8'hE0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 8'h00, 8'h00, 9'd0, 1});
    vecs.push_back(vec_t'{0, 1, 8'hE1, 0, 0, 8'h00, 8'h00, 8'h00, 1, 8'h00, 8'h00, 9'd1, 1});
    vecs.push_back(vec_t'{0, 1, 8'hE2, 0, 0, 8'h00, 8'h00, 8'h00, 1, 8'h00, 8'h00, 9'd2, 1});
    vecs.push_back(vec_t'{0, 1, 8'hE3, 0, 0, 8'h00, 8'h00, 8'h00, 1, 8'h00, 8'h00, 9'd3, 1});
    vecs.push_back(vec_t'{0, 0, 8'h00, 1, 0, 8'h00, 8'h01, 8'h00, 0, 8'hE0, 8'hE1, 9'd4, 1});
    vecs.push_back(vec_t'{0, 0, 8'h00, 1, 0, 8'h03, 8'h02, 8'h00, 0, 8'hE3, 8'hE2, 9'd4, 1});

    // Reset state.
    repeat (2) @(posedge Clock);
    #1;
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_ready", 32'(load_ready), 32'd1);
    check("rst_count", 32'(load_count), 32'd0);
    check("rst_conflict", 32'(conflict), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      load_start = vecs[i].st;
      load_valid = vecs[i].lv;
      load_data  = vecs[i].ld;
      MemRead    = vecs[i].mr;
      MemWrite   = vecs[i].mw;
      InstrAddr  = vecs[i].ia;
      DataAddr   = vecs[i].da;
      WriteData  = vecs[i].wd;
      #1;
      check($sformatf("v%0d_hold", i), 32'(cpu_hold), 32'(vecs[i].e_hold));
      check($sformatf("v%0d_ready", i), 32'(load_ready), 32'(vecs[i].e_hold));
      check($sformatf("v%0d_instr", i), 32'(Instrucao), 32'(vecs[i].e_instr));
      check($sformatf("v%0d_ledado", i), 32'(LeDado), 32'(vecs[i].e_led));
      check($sformatf("v%0d_count", i), 32'(load_count), 32'(vecs[i].e_cnt));
      check($sformatf("v%0d_conflict", i), 32'(conflict), 32'(vecs[i].e_conf));
      @(posedge Clock);
      #1;
    end

    // Reload requested from RUN, then reset after two bytes of the new image.
    MemRead    = 1'b0;
    load_valid = 1'b0;
    load_start = 1'b1;
    @(posedge Clock);
    #1;
    load_start = 1'b0;
    load_valid = 1'b1;
    load_data  = 8'h55;
    @(posedge Clock);
    #1;
    load_data  = 8'h66;
    @(posedge Clock);
    #1;
    load_valid = 1'b0;
    #1;
    check("mid_count", 32'(load_count), 32'd2);
    check("mid_hold", 32'(cpu_hold), 32'd1);
    check("mid_conflict_kept", 32'(conflict), 32'd1);
    reset = 1'b1;
    #1;
    check("async_rst_count", 32'(load_count), 32'd0);
    check("async_rst_hold", 32'(cpu_hold), 32'd1);
    check("async_rst_conflict", 32'(conflict), 32'd0);
    @(posedge Clock);
    #1;
    reset = 1'b0;

    // From here the reference model tracks every cycle.
    run_m  = 0;
    cnt_m  = 0;
    conf_m = 0;
    InstrAddr = '0;
    for (int k = 0; k < int'(LEN); k++) begin
      load_valid = 1'b1;
      load_data  = 8'(k + 1);
      model_cycle();
    end
    load_valid = 1'b0;
    check("reload_word0", 32'(Instrucao), 32'h01);

    // Give every address a known value through core stores.
    for (int a = 0; a < (2 ** AW); a++) begin
      MemWrite  = 1'b1;
      DataAddr  = 8'(a);
      WriteData = 8'($urandom);
      model_cycle();
    end
    MemWrite = 1'b0;

    for (int n = 0; n < 1500; n++) begin
      load_start = ($urandom_range(0, 31) == 0);
      load_valid = $urandom_range(0, 1) == 1;
      load_data  = 8'($urandom);
      MemRead    = $urandom_range(0, 1) == 1;
      MemWrite   = $urandom_range(0, 2) == 0;
      InstrAddr  = 8'($urandom);
      DataAddr   = ($urandom_range(0, 3) == 0) ? InstrAddr : 8'($urandom);
      WriteData  = 8'($urandom);
      model_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
